// File: rtl/instr_sequencer.sv
// instr_sequencer: host-side issuer for the controller instruction bus.
// The host fills a small word FIFO, then a start command emits a header word
// followed by word_count FIFO words, each held on instruct for HOLD_CYCLES.
module instr_sequencer #(
    parameter int MAX_WORDS   = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        flush,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [7:0]  word_count,
    output logic [31:0] instruct,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int PTR_W  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int OCC_W  = PTR_W + 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [OCC_W-1:0]  OCC_FULL  = OCC_W'(MAX_WORDS);
    localparam logic [7:0]        MAX_CNT   = 8'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_END
    } state_t;

    state_t             state;
    logic [31:0]        mem [MAX_WORDS];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occ;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [7:0]         remaining;

    logic               full;
    logic               push;
    logic [7:0]         avail;
    logic               start_ok;

    // FIFO handshake and start qualification; flush empties the FIFO first,
    // so a same-cycle start only sees the occupancy left after the flush.
    always_comb begin
        full       = (occ == OCC_FULL);
        load_ready = !full && (state == S_IDLE);
        push       = load_valid && load_ready && !flush;
        avail      = flush ? 8'd0 : 8'(occ);
        start_ok   = (word_count <= avail) && (word_count <= MAX_CNT);
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= load_data;
        end
    end

    // Sequencer FSM together with FIFO pointer/occupancy bookkeeping.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            instruct  <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            hold_cnt  <= '0;
            remaining <= 8'd0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    instruct <= 32'h0;
                    if (flush) begin
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        occ    <= '0;
                    end else if (push) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        occ    <= occ + 1'b1;
                    end
                    if (start) begin
                        if (start_ok) begin
                            state     <= S_HDR;
                            instruct  <= {1'b1, 15'h0, word_count, opcode};
                            busy      <= 1'b1;
                            hold_cnt  <= '0;
                            remaining <= word_count;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                // Header and data words share the same hold/advance behaviour:
                // once a word has been held long enough, pop the next or finish.
                S_HDR, S_DATA: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (remaining != 8'd0) begin
                            state     <= S_DATA;
                            instruct  <= mem[rd_ptr];
                            rd_ptr    <= rd_ptr + 1'b1;
                            occ       <= occ - 1'b1;
                            remaining <= remaining - 1'b1;
                        end else begin
                            state    <= S_END;
                            instruct <= 32'h0;
                            done     <= 1'b1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_END: begin
                    state    <= S_IDLE;
                    instruct <= 32'h0;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    instruct <= 32'h0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer with MAX_WORDS=8, HOLD_CYCLES=2.
module tb_instr_sequencer;

    logic        clock;
    logic        rst_n;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_ready;
    logic        flush;
    logic        start;
    logic [7:0]  opcode;
    logic [7:0]  word_count;
    logic [31:0] instruct;
    logic        busy;
    logic        done;
    logic        error;

    int total;
    int bad;

    instr_sequencer #(
        .MAX_WORDS  (8),
        .HOLD_CYCLES(2)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .flush     (flush),
        .start     (start),
        .opcode    (opcode),
        .word_count(word_count),
        .instruct  (instruct),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w);
        load_valid = 1'b1;
        load_data  = w;
        step();
        load_valid = 1'b0;
        load_data  = 32'h0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [7:0] cnt);
        start      = 1'b1;
        opcode     = op;
        word_count = cnt;
        step();
        start      = 1'b0;
        opcode     = 8'h0;
        word_count = 8'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (instruct !== 32'h0 || load_ready !== 1'b1 || busy !== 1'b0 ||
                done !== 1'b0 || error !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cycle %0d: instruct=%h load_ready=%b busy=%b done=%b error=%b want 0/1/0/0/0",
                         i, instruct, load_ready, busy, done, error);
            end
            step();
        end
    endtask

    task automatic test_key_load();
        logic [31:0] seq[$];
        logic [31:0] keys[4];
        keys[0] = 32'he0318a99;
        keys[1] = 32'h23f247b3;
        keys[2] = 32'hed8ff212;
        keys[3] = 32'hef0bc156;
        for (int k = 0; k < 4; k++) load_word(keys[k]);
        seq.push_back(32'h80000400);
        seq.push_back(32'h80000400);
        for (int k = 0; k < 4; k++) begin
            seq.push_back(keys[k]);
            seq.push_back(keys[k]);
        end
        issue(8'h00, 8'd4);
        for (int i = 0; i < seq.size(); i++) begin
            total++;
            if (instruct !== seq[i] || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL key_seq cycle %0d: instruct=%h busy=%b done=%b want %h/1/0",
                         i, instruct, busy, done, seq[i]);
            end
            total++;
            if (load_ready !== 1'b0) begin
                bad++;
                $display("FAIL key_load_ready_busy cycle %0d: load_ready=%b want 0", i, load_ready);
            end
            step();
        end
        total++;
        if (instruct !== 32'h0 || done !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL key_end: instruct=%h done=%b busy=%b want 0/1/1", instruct, done, busy);
        end
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL key_idle_after: busy=%b done=%b load_ready=%b want 0/0/1", busy, done, load_ready);
        end
    endtask

    task automatic test_header_only();
        issue(8'h07, 8'd0);
        total++;
        if (instruct !== 32'h80000007 || busy !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL hdr_only_c1: instruct=%h busy=%b error=%b want 80000007/1/0", instruct, busy, error);
        end
        // A start while busy must be ignored silently.
        issue(8'h55, 8'd5);
        total++;
        if (instruct !== 32'h80000007 || error !== 1'b0) begin
            bad++;
            $display("FAIL hdr_only_c2: instruct=%h error=%b want 80000007/0", instruct, error);
        end
        step();
        total++;
        if (instruct !== 32'h0 || done !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL hdr_only_end: instruct=%h done=%b error=%b want 0/1/0", instruct, done, error);
        end
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL hdr_only_idle: busy=%b done=%b error=%b want 0/0/0", busy, done, error);
        end
    endtask

    task automatic test_reject();
        logic [31:0] seq[$];
        load_word(32'h11111111);
        load_word(32'h22222222);
        issue(8'h11, 8'd3);
        total++;
        if (error !== 1'b1 || instruct !== 32'h0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reject_pulse: error=%b instruct=%h busy=%b want 1/0/0", error, instruct, busy);
        end
        step();
        total++;
        if (error !== 1'b0 || instruct !== 32'h0) begin
            bad++;
            $display("FAIL reject_clear: error=%b instruct=%h want 0/0", error, instruct);
        end
        seq = '{32'h80000211, 32'h80000211, 32'h11111111, 32'h11111111,
                32'h22222222, 32'h22222222};
        issue(8'h11, 8'd2);
        for (int i = 0; i < seq.size(); i++) begin
            total++;
            if (instruct !== seq[i] || error !== 1'b0) begin
                bad++;
                $display("FAIL reject_retry cycle %0d: instruct=%h error=%b want %h/0",
                         i, instruct, error, seq[i]);
            end
            step();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL reject_retry_done: done=%b want 1", done);
        end
        step();
    endtask

    task automatic test_full_wrap();
        logic [31:0] seq[$];
        for (int k = 0; k < 8; k++) begin
            total++;
            if (load_ready !== 1'b1) begin
                bad++;
                $display("FAIL fill_ready word %0d: load_ready=%b want 1", k, load_ready);
            end
            load_word(32'hA0000000 + 32'(k));
        end
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: load_ready=%b want 0", load_ready);
        end
        load_word(32'hDEADBEEF);
        seq.push_back(32'h80000522);
        seq.push_back(32'h80000522);
        for (int k = 0; k < 5; k++) begin
            seq.push_back(32'hA0000000 + 32'(k));
            seq.push_back(32'hA0000000 + 32'(k));
        end
        issue(8'h22, 8'd5);
        for (int i = 0; i < seq.size(); i++) begin
            total++;
            if (instruct !== seq[i]) begin
                bad++;
                $display("FAIL send5 cycle %0d: instruct=%h want %h", i, instruct, seq[i]);
            end
            step();
        end
        step();
        for (int k = 8; k < 13; k++) load_word(32'hA0000000 + 32'(k));
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL refill_full_ready: load_ready=%b want 0", load_ready);
        end
        seq.delete();
        seq.push_back(32'h80000833);
        seq.push_back(32'h80000833);
        for (int k = 5; k < 13; k++) begin
            seq.push_back(32'hA0000000 + 32'(k));
            seq.push_back(32'hA0000000 + 32'(k));
        end
        issue(8'h33, 8'd8);
        for (int i = 0; i < seq.size(); i++) begin
            total++;
            if (instruct !== seq[i]) begin
                bad++;
                $display("FAIL send8_wrap cycle %0d: instruct=%h want %h", i, instruct, seq[i]);
            end
            step();
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL send8_done: done=%b want 1", done);
        end
        step();
        issue(8'h01, 8'd1);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL wrap_empty_after: error=%b want 1", error);
        end
        step();
    endtask

    task automatic test_abort();
        load_word(32'hC0000000);
        load_word(32'hC0000001);
        load_word(32'hC0000002);
        issue(8'h44, 8'd3);
        step();
        step();
        step();
        step();
        total++;
        if (instruct !== 32'hC0000001) begin
            bad++;
            $display("FAIL abort_pre: instruct=%h want c0000001", instruct);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (instruct !== 32'h0 || busy !== 1'b0 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_async: instruct=%h busy=%b load_ready=%b want 0/0/1",
                     instruct, busy, load_ready);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        issue(8'h44, 8'd1);
        total++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_fifo_empty: error=%b busy=%b want 1/0", error, busy);
        end
        step();
    endtask

    task automatic test_flush();
        load_word(32'hF0000000);
        load_word(32'hF0000001);
        load_word(32'hF0000002);
        flush = 1'b1;
        step();
        flush = 1'b0;
        issue(8'h09, 8'd1);
        total++;
        if (error !== 1'b1 || instruct !== 32'h0) begin
            bad++;
            $display("FAIL flush_reject: error=%b instruct=%h want 1/0", error, instruct);
        end
        step();
        // Flush together with a load: the load is dropped.
        load_word(32'hF0000003);
        flush      = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hF0000004;
        step();
        flush      = 1'b0;
        load_valid = 1'b0;
        issue(8'h09, 8'd1);
        total++;
        if (error !== 1'b1) begin
            bad++;
            $display("FAIL flush_load_drop: error=%b want 1", error);
        end
        step();
        // Flush together with start: evaluated against an empty FIFO.
        load_word(32'hF0000005);
        flush = 1'b1;
        issue(8'h0A, 8'd1);
        flush = 1'b0;
        total++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_start: error=%b busy=%b want 1/0", error, busy);
        end
        step();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        flush      = 1'b0;
        start      = 1'b0;
        opcode     = 8'h0;
        word_count = 8'h0;
        test_reset();
        test_key_load();
        test_header_only();
        test_reject();
        test_full_wrap();
        test_abort();
        test_flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Host-side issuer for the crypto coprocessor controller's 32-bit instruction bus. The host loads data words into an internal FIFO and triggers a command. The block then drives a header word followed by the requested number of data words on `instruct`, each held for a fixed number of cycles. It sits between the host/bus interface and `controller`, and produces the stream the controller consumes: command header first, then key/data slices least-significant word first.

## Interface

Parameters:
- MAX_WORDS, 8: FIFO depth in 32-bit words; power of two, 2..16.
- HOLD_CYCLES, 2: cycles each word stays on `instruct`; ≥1.

Ports:
- clock  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- load_valid  in  1  host offers `load_data`.
- load_data  in  32  data word, LS word of a key loaded first.
- load_ready  out  1  FIFO accepts a word this cycle.
- flush  in  1  empties the FIFO; honoured only in IDLE.
- start  in  1  command request; honoured only in IDLE.
- opcode  in  8  command opcode placed in header bits [7:0].
- word_count  in  8  number of data words to send after the header; range 0..MAX_WORDS.
- instruct  out  32  instruction word to `controller`.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- error  out  1  one-cycle pulse when a start is rejected.

## Operation

- Header format: bit31=1, [30:16]=0, [15:8]=word_count, [7:0]=opcode. Data words are sent unmodified. When idle, `instruct` = 32'h0.
- FIFO: `load_ready` = !full && state==IDLE. A word is written when `load_valid && load_ready`. Occupancy saturates at MAX_WORDS; there is no overwrite.
- States:
  - IDLE: `start` with word_count ≤ occupancy (occupancy sampled before the same-cycle load) and word_count ≤ MAX_WORDS → HDR, latching opcode and count. Otherwise `start` → pulse `error`, stay in IDLE, FIFO untouched.
  - HDR: drive the header for HOLD_CYCLES. Then go to DATA if count>0, else END.
  - DATA: pop the FIFO head, drive it for HOLD_CYCLES, decrement the remaining count. Go to END when the remaining count reaches 0.
  - END: `instruct`=0, `done`=1 for one cycle, then → IDLE.
- Words beyond word_count stay in the FIFO for the next command.
- `flush` in IDLE clears occupancy and pointers in one cycle. If `flush` and `load_valid` occur together, the result is an empty FIFO and the load is dropped. If `flush` and `start` occur together, `flush` wins and the start is evaluated against an empty FIFO.
- `start` and `flush` outside IDLE are ignored with no error.
- Pointers are log2(MAX_WORDS) bits and wrap modulo MAX_WORDS. Occupancy is log2(MAX_WORDS)+1 bits.

## Timing

- Reset values: instruct=0, busy=0, done=0, error=0, load_ready=1, FIFO empty, state IDLE. Asserting `rst_n` low mid-sequence aborts immediately (asynchronous), and the FIFO contents are discarded.
- Start accepted at edge T:
  - Header on `instruct` from T+1 through T+HOLD_CYCLES.
  - Data word i (0-based) during T+1+HOLD_CYCLES·(i+1) … T+HOLD_CYCLES·(i+2).
  - END cycle at T+1+HOLD_CYCLES·(count+1).
- `busy` is high from T+1 through the END cycle inclusive. `done` coincides with END. `error` is asserted the cycle after the rejected start edge.
- All outputs are registered; there is no combinational path from inputs to `instruct`.
- A new `start` is accepted at the earliest on the edge ending the END cycle+1, i.e. back in IDLE.

## Test plan

- Reset and idle: hold rst_n low, then release. Required: instruct=0, load_ready=1, busy=0 for 10 cycles with no stimulus.
- Key load, HOLD_CYCLES=2:
  - Stimulus: load e0318a99, 23f247b3, ed8ff212, ef0bc156, then start with opcode=8'h00, count=4.
  - Required: 80000400 ×2, e0318a99 ×2, 23f247b3 ×2, ed8ff212 ×2, ef0bc156 ×2, then 0 with done=1; busy high for 11 cycles.
- Header-only: start with opcode=8'h07, count=0 on an empty FIFO. Required: 80000007 for 2 cycles, then done; no error.
- Rejection: load 2 words, start with count=3. Required: error pulse, instruct stays 0, occupancy still 2. A subsequent start with count=2 succeeds.
- Boundary and wrap-around:
  - Fill 8 words; the 9th offer sees load_ready=0 and is dropped.
  - Send 5 words, load 5 more (pointer wrap), send 8. Required: words come out in FIFO order across the wrap.
- Abort and flush:
  - Pull rst_n low during the second data word. Required: instruct=0 immediately; after release the FIFO is empty.
  - Flush with 3 words loaded. Required: a following start with count=1 raises error.
